// File: rtl/multicycle_core.sv
// Multicycle RV32I-subset core: one shared memory port, FETCH/DECODE/EXEC/MEM/WB
// sequencing, bus-timeout supervision and a retired-instruction counter.
module multicycle_core #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        halted,
  output logic        trap,
  output logic        retire,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_SLT    = 4'd4,
    OP_ADDI   = 4'd5,
    OP_LUI    = 4'd6,
    OP_LW     = 4'd7,
    OP_SW     = 4'd8,
    OP_BEQ    = 4'd9,
    OP_BNE    = 4'd10,
    OP_JAL    = 4'd11,
    OP_EBREAK = 4'd12,
    OP_ILL    = 4'd13
  } op_t;

  localparam logic [31:0] TIMEOUT_LIM = 32'(BUS_TIMEOUT);

  function automatic op_t decode_op(input logic [31:0] ir);
    op_t op;
    op = OP_ILL;
    case (ir[6:0])
      7'b0110011: begin
        case ({ir[31:25], ir[14:12]})
          10'b0000000_000: op = OP_ADD;
          10'b0100000_000: op = OP_SUB;
          10'b0000000_111: op = OP_AND;
          10'b0000000_110: op = OP_OR;
          10'b0000000_010: op = OP_SLT;
          default:         op = OP_ILL;
        endcase
      end
      7'b0010011: op = (ir[14:12] == 3'b000) ? OP_ADDI : OP_ILL;
      7'b0110111: op = OP_LUI;
      7'b0000011: op = (ir[14:12] == 3'b010) ? OP_LW : OP_ILL;
      7'b0100011: op = (ir[14:12] == 3'b010) ? OP_SW : OP_ILL;
      7'b1100011: begin
        case (ir[14:12])
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          default: op = OP_ILL;
        endcase
      end
      7'b1101111: op = OP_JAL;
      7'b1110011: op = (ir == 32'h0010_0073) ? OP_EBREAK : OP_ILL;
      default:    op = OP_ILL;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] decode_imm(input logic [31:0] ir);
    logic [31:0] imm;
    case (ir[6:0])
      7'b0010011, 7'b0000011: imm = {{20{ir[31]}}, ir[31:20]};
      7'b0100011:             imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      7'b1100011:             imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      7'b0110111:             imm = {ir[31:12], 12'h000};
      7'b1101111:             imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:                imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

  function automatic logic [31:0] alu(input op_t op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      OP_ADD, OP_ADDI: r = a + b;
      OP_SUB:          r = a - b;
      OP_AND:          r = a & b;
      OP_OR:           r = a | b;
      OP_SLT:          r = {31'd0, ($signed(a) < $signed(b))};
      OP_LUI:          r = b;
      default:         r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_t      state_r, state_next_s;
  op_t         op_r, op_dec_s;
  logic [31:0] pc_r, pc_next_s, ir_r, imm_r, rs1_val_r, rs2_val_r, res_r, res_next_s;
  logic [31:0] wait_cnt_r, wait_next_s;
  logic [31:0] rf_r [32];
  logic        mem_req_r, mem_we_r, halted_r, trap_r, retire_r;
  logic [31:0] mem_addr_r, mem_wdata_r, instret_r;
  logic        req_next_s, we_next_s, ir_load_s, dec_load_s, rf_we_s, retire_s, trap_set_s;
  logic [31:0] addr_next_s, wdata_next_s, imm_dec_s, rs1_rd_s, rs2_rd_s;
  logic [31:0] pc_plus4_s, target_s, ea_s, alu_s;
  logic        taken_s, timeout_s;

  assign op_dec_s   = decode_op(ir_r);
  assign imm_dec_s  = decode_imm(ir_r);
  assign rs1_rd_s   = (ir_r[19:15] == 5'd0) ? 32'h0000_0000 : rf_r[ir_r[19:15]];
  assign rs2_rd_s   = (ir_r[24:20] == 5'd0) ? 32'h0000_0000 : rf_r[ir_r[24:20]];
  assign pc_plus4_s = pc_r + 32'd4;
  assign target_s   = pc_r + imm_r;
  assign ea_s       = rs1_val_r + imm_r;
  assign alu_s      = alu(op_r, rs1_val_r,
                          ((op_r == OP_ADDI) || (op_r == OP_LUI)) ? imm_r : rs2_val_r);
  assign taken_s    = (op_r == OP_BEQ) ? (rs1_val_r == rs2_val_r) : (rs1_val_r != rs2_val_r);
  // A zero limit disables supervision; otherwise this wait cycle is the last one allowed.
  assign timeout_s  = (TIMEOUT_LIM != 32'd0) && ((wait_cnt_r + 32'd1) == TIMEOUT_LIM);

  // Next-state, next-output and datapath-control decode.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    req_next_s   = 1'b0;
    we_next_s    = 1'b0;
    addr_next_s  = mem_addr_r;
    wdata_next_s = mem_wdata_r;
    wait_next_s  = 32'd0;
    res_next_s   = res_r;
    ir_load_s    = 1'b0;
    dec_load_s   = 1'b0;
    rf_we_s      = 1'b0;
    retire_s     = 1'b0;
    trap_set_s   = 1'b0;
    case (state_r)
      FETCH: begin
        if (!mem_req_r) begin
          req_next_s  = 1'b1;
          addr_next_s = pc_r;
        end else if (mem_ready) begin
          state_next_s = DECODE;
          ir_load_s    = 1'b1;
        end else if (timeout_s) begin
          state_next_s = HALT;
          trap_set_s   = 1'b1;
        end else begin
          req_next_s  = 1'b1;
          wait_next_s = wait_cnt_r + 32'd1;
        end
      end
      DECODE: begin
        dec_load_s = 1'b1;
        if (op_dec_s == OP_ILL) begin
          state_next_s = HALT;
          trap_set_s   = 1'b1;
        end else if (op_dec_s == OP_EBREAK) begin
          state_next_s = HALT;
        end else begin
          state_next_s = EXEC;
        end
      end
      EXEC: begin
        case (op_r)
          OP_BEQ, OP_BNE: begin
            if (taken_s && (target_s[1:0] != 2'b00)) begin
              state_next_s = HALT;
              trap_set_s   = 1'b1;
            end else begin
              pc_next_s    = taken_s ? target_s : pc_plus4_s;
              retire_s     = 1'b1;
              state_next_s = FETCH;
              req_next_s   = 1'b1;
              addr_next_s  = taken_s ? target_s : pc_plus4_s;
            end
          end
          OP_LW, OP_SW: begin
            if (ea_s[1:0] != 2'b00) begin
              state_next_s = HALT;
              trap_set_s   = 1'b1;
            end else begin
              state_next_s = MEM;
              req_next_s   = 1'b1;
              we_next_s    = (op_r == OP_SW);
              addr_next_s  = ea_s;
              wdata_next_s = rs2_val_r;
            end
          end
          OP_JAL: begin
            if (target_s[1:0] != 2'b00) begin
              state_next_s = HALT;
              trap_set_s   = 1'b1;
            end else begin
              res_next_s   = pc_plus4_s;
              state_next_s = WB;
            end
          end
          default: begin
            res_next_s   = alu_s;
            state_next_s = WB;
          end
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          if (op_r == OP_LW) begin
            res_next_s   = mem_rdata;
            state_next_s = WB;
          end else begin
            pc_next_s    = pc_plus4_s;
            retire_s     = 1'b1;
            state_next_s = FETCH;
            req_next_s   = 1'b1;
            addr_next_s  = pc_plus4_s;
          end
        end else if (timeout_s) begin
          state_next_s = HALT;
          trap_set_s   = 1'b1;
        end else begin
          req_next_s  = 1'b1;
          we_next_s   = mem_we_r;
          wait_next_s = wait_cnt_r + 32'd1;
        end
      end
      WB: begin
        rf_we_s      = (ir_r[11:7] != 5'd0);
        pc_next_s    = (op_r == OP_JAL) ? target_s : pc_plus4_s;
        retire_s     = 1'b1;
        state_next_s = FETCH;
        req_next_s   = 1'b1;
        addr_next_s  = (op_r == OP_JAL) ? target_s : pc_plus4_s;
      end
      HALT: begin
        state_next_s = HALT;
      end
      default: begin
        state_next_s = HALT;
        trap_set_s   = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= FETCH;
    else      state_r <= state_next_s;
  end

  // Datapath registers: PC, IR, decoded operands, result and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r       <= RESET_PC;
      ir_r       <= 32'h0000_0000;
      op_r       <= OP_ILL;
      imm_r      <= 32'h0000_0000;
      rs1_val_r  <= 32'h0000_0000;
      rs2_val_r  <= 32'h0000_0000;
      res_r      <= 32'h0000_0000;
      wait_cnt_r <= 32'd0;
    end else begin
      pc_r       <= pc_next_s;
      res_r      <= res_next_s;
      wait_cnt_r <= wait_next_s;
      if (ir_load_s) ir_r <= mem_rdata;
      else           ir_r <= ir_r;
      if (dec_load_s) begin
        op_r      <= op_dec_s;
        imm_r     <= imm_dec_s;
        rs1_val_r <= rs1_rd_s;
        rs2_val_r <= rs2_rd_s;
      end else begin
        op_r      <= op_r;
        imm_r     <= imm_r;
        rs1_val_r <= rs1_val_r;
        rs2_val_r <= rs2_val_r;
      end
    end
  end

  // Registered bus and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      halted_r    <= 1'b0;
      trap_r      <= 1'b0;
      retire_r    <= 1'b0;
      instret_r   <= 32'd0;
    end else begin
      mem_req_r   <= req_next_s;
      mem_we_r    <= we_next_s;
      mem_addr_r  <= addr_next_s;
      mem_wdata_r <= wdata_next_s;
      halted_r    <= (state_next_s == HALT);
      trap_r      <= trap_r | trap_set_s;
      retire_r    <= retire_s;
      instret_r   <= instret_r + {31'd0, retire_s};
    end
  end

  // Register file; entry 0 is never written so x0 stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_r[i] <= 32'h0000_0000;
    end else if (rf_we_s) begin
      rf_r[ir_r[11:7]] <= res_r;
    end else begin
      rf_r[0] <= 32'h0000_0000;
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = {mem_addr_r[31:2], 2'b00};
  assign mem_wdata = mem_wdata_r;
  assign halted    = halted_r;
  assign trap      = trap_r;
  assign retire    = retire_r;
  assign instret   = instret_r;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: a word memory with programmable wait states
// and hang windows, linear test sequence with immediate-assertion checks.
module tb_multicycle_core;

  logic        clk, rst;
  logic        mem_req, mem_we, mem_ready, halted, trap, retire;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, instret;

  multicycle_core #(.RESET_PC(32'h0000_0000), .BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .trap(trap), .retire(retire), .instret(instret)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wait_cfg = 0;
  int wcnt = 0;
  int hang_cyc = 0;
  int unstable = 0;
  int bad_align = 0;
  logic        hang = 1'b0;
  logic [31:0] hang_addr = 32'h0;
  logic [31:0] mem [64];
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;
  logic [31:0] wr_addr_q[$], wr_data_q[$], acc_addr_q[$];
  int          acc_cyc_q[$], ret_cyc_q[$];
  logic [31:0] ret_inst_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder and retire monitor, acting on the falling edge.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (mem_addr[1:0] !== 2'b00) bad_align++;
        if (wcnt == 0) begin
          cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
        end else if (mem_addr !== cap_addr || mem_we !== cap_we ||
                     (cap_we && mem_wdata !== cap_wdata)) begin
          unstable++;
        end
        if (hang && mem_addr >= hang_addr) begin
          mem_ready = 1'b0; wcnt++; hang_cyc++;
        end else if (wcnt >= wait_cfg) begin
          mem_ready = 1'b1;
          if (mem_we) begin
            mem[mem_addr[7:2]] = mem_wdata;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
          end else begin
            mem_rdata = mem[mem_addr[7:2]];
          end
          acc_addr_q.push_back(mem_addr);
          acc_cyc_q.push_back(cyc);
          wcnt = 0;
        end else begin
          mem_ready = 1'b0; wcnt++;
        end
      end else begin
        mem_ready = 1'b0; wcnt = 0;
      end
      if (retire === 1'b1) begin
        ret_cyc_q.push_back(cyc);
        ret_inst_q.push_back(instret);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    check("rst_async_req", {31'd0, mem_req}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_trap", {31'd0, trap}, 32'd0);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_instret", instret, 32'd0);
    wr_addr_q.delete(); wr_data_q.delete(); acc_addr_q.delete(); acc_cyc_q.delete();
    ret_cyc_q.delete(); ret_inst_q.delete();
    hang_cyc = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_until_halt(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (halted === 1'b1) break;
    end
  endtask

  initial begin
    logic [31:0] exp_wa [7];
    logic [31:0] exp_wd [7];
    int n;
    rst = 1'b0;

    // ALU sequence, zero wait states; results exposed through stores.
    clear_mem();
    mem[0]  = enc_i(12'd5,   5'd0, 3'b000, 5'd1, 7'b0010011);
    mem[1]  = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'b0010011);
    mem[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    mem[3]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd6);
    mem[4]  = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd7);
    mem[5]  = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd8);
    mem[6]  = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd9);
    mem[7]  = {20'h12345, 5'd10, 7'b0110111};
    mem[8]  = enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'b0010011);
    mem[9]  = enc_s(12'h080, 5'd3, 5'd0);
    mem[10] = enc_s(12'h084, 5'd6, 5'd0);
    mem[11] = enc_s(12'h088, 5'd7, 5'd0);
    mem[12] = enc_s(12'h08C, 5'd8, 5'd0);
    mem[13] = enc_s(12'h090, 5'd9, 5'd0);
    mem[14] = enc_s(12'h094, 5'd10, 5'd0);
    mem[15] = enc_s(12'h098, 5'd0, 5'd0);
    mem[16] = 32'h0010_0073;
    wait_cfg = 0; hang = 1'b0;
    apply_reset();
    run_until_halt(200);
    check("alu_halted", {31'd0, halted}, 32'd1);
    check("alu_trap", {31'd0, trap}, 32'd0);
    check("alu_instret", instret, 32'd16);
    check("alu_ret_cnt", ret_cyc_q.size(), 32'd16);
    if (ret_cyc_q.size() >= 11) begin
      check("alu_lat_1", ret_cyc_q[1] - ret_cyc_q[0], 32'd4);
      check("alu_lat_2", ret_cyc_q[2] - ret_cyc_q[1], 32'd4);
      check("alu_instret_3", ret_inst_q[2], 32'd3);
      check("sw_lat_0ws", ret_cyc_q[10] - ret_cyc_q[9], 32'd4);
    end
    exp_wa = '{32'h80, 32'h84, 32'h88, 32'h8C, 32'h90, 32'h94, 32'h98};
    exp_wd = '{32'd2, 32'd8, 32'd1, 32'd5, 32'hFFFF_FFFD, 32'h1234_5000, 32'd0};
    check("alu_nwr", wr_addr_q.size(), 32'd7);
    n = (wr_addr_q.size() < 7) ? wr_addr_q.size() : 7;
    for (int i = 0; i < n; i++) begin
      check($sformatf("alu_wa%0d", i), wr_addr_q[i], exp_wa[i]);
      check($sformatf("alu_wd%0d", i), wr_data_q[i], exp_wd[i]);
    end

    // Store/load with three wait states on every access, plus jal link.
    clear_mem();
    mem[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
    mem[1]  = enc_j(21'h1C, 5'd5);
    mem[8]  = enc_s(12'h008, 5'd1, 5'd0);
    mem[9]  = enc_i(12'd8, 5'd0, 3'b010, 5'd4, 7'b0000011);
    mem[10] = enc_s(12'h044, 5'd4, 5'd0);
    mem[11] = enc_s(12'h048, 5'd5, 5'd0);
    mem[12] = 32'h0010_0073;
    wait_cfg = 3;
    apply_reset();
    run_until_halt(300);
    check("ldst_halted", {31'd0, halted}, 32'd1);
    check("ldst_trap", {31'd0, trap}, 32'd0);
    check("ldst_instret", instret, 32'd6);
    check("ldst_nwr", wr_addr_q.size(), 32'd3);
    if (wr_addr_q.size() >= 3) begin
      check("sw_addr", wr_addr_q[0], 32'h08);
      check("sw_data", wr_data_q[0], 32'd5);
      check("lw_x4", wr_data_q[1], 32'd5);
      check("jal_link", wr_data_q[2], 32'd8);
    end
    if (ret_cyc_q.size() >= 4) begin
      check("jal_lat_3ws", ret_cyc_q[1] - ret_cyc_q[0], 32'd7);
      check("sw_lat_3ws", ret_cyc_q[2] - ret_cyc_q[1], 32'd10);
      check("lw_lat_3ws", ret_cyc_q[3] - ret_cyc_q[2], 32'd11);
    end
    wait_cfg = 0;

    // Taken beq backwards from 0x10.
    clear_mem();
    mem[0] = enc_j(21'h10, 5'd0);
    mem[4] = enc_b(13'h1FF8, 5'd0, 5'd0, 3'b000);
    mem[2] = 32'h0010_0073;
    apply_reset();
    run_until_halt(100);
    check("beq_nacc", acc_addr_q.size(), 32'd3);
    if (acc_addr_q.size() >= 3) begin
      check("beq_target", acc_addr_q[2], 32'h08);
      check("beq_lat", acc_cyc_q[2] - acc_cyc_q[1], 32'd3);
    end
    check("beq_instret", instret, 32'd2);

    // Not-taken bne at 0x10.
    clear_mem();
    mem[0] = enc_j(21'h10, 5'd0);
    mem[4] = enc_b(13'h1FF8, 5'd0, 5'd0, 3'b001);
    mem[5] = 32'h0010_0073;
    apply_reset();
    run_until_halt(100);
    check("bne_nacc", acc_addr_q.size(), 32'd3);
    if (acc_addr_q.size() >= 3) check("bne_next", acc_addr_q[2], 32'h14);
    check("bne_trap", {31'd0, trap}, 32'd0);

    // Illegal opcode halts with trap and stops the bus.
    clear_mem();
    mem[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1, 7'b0010011);
    mem[1] = 32'h0000_0000;
    apply_reset();
    run_until_halt(100);
    check("ill_halted", {31'd0, halted}, 32'd1);
    check("ill_trap", {31'd0, trap}, 32'd1);
    check("ill_instret", instret, 32'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      if (mem_req === 1'b1) n++;
    end
    check("ill_no_req", n, 32'd0);
    check("ill_nacc", acc_addr_q.size(), 32'd2);

    // Misaligned load address.
    clear_mem();
    mem[0] = enc_i(12'd6, 5'd0, 3'b010, 5'd2, 7'b0000011);
    apply_reset();
    run_until_halt(100);
    check("mis_halted", {31'd0, halted}, 32'd1);
    check("mis_trap", {31'd0, trap}, 32'd1);
    check("mis_nacc", acc_addr_q.size(), 32'd1);

    // Fetch never acknowledged: timeout after four wait cycles.
    clear_mem();
    hang = 1'b1; hang_addr = 32'h0;
    apply_reset();
    run_until_halt(50);
    check("tof_halted", {31'd0, halted}, 32'd1);
    check("tof_trap", {31'd0, trap}, 32'd1);
    check("tof_waits", hang_cyc, 32'd4);
    check("tof_req_low", {31'd0, mem_req}, 32'd0);

    // Load never acknowledged: timeout in the data phase.
    clear_mem();
    mem[0] = enc_i(12'h080, 5'd0, 3'b010, 5'd2, 7'b0000011);
    hang = 1'b1; hang_addr = 32'h80;
    apply_reset();
    run_until_halt(50);
    check("tom_trap", {31'd0, trap}, 32'd1);
    check("tom_waits", hang_cyc, 32'd4);
    check("tom_instret", instret, 32'd0);

    // Reset asserted during a stalled store.
    clear_mem();
    mem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
    mem[1] = enc_s(12'h080, 5'd1, 5'd0);
    mem[2] = 32'h0010_0073;
    hang = 1'b1; hang_addr = 32'h80;
    apply_reset();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (mem_req === 1'b1 && mem_we === 1'b1) begin n = 1; break; end
    end
    check("rsm_store_seen", n, 32'd1);
    repeat (2) @(posedge clk);
    #2;
    check("rsm_instret_pre", instret, 32'd1);
    rst = 1'b0;
    #1;
    check("rsm_req_drop", {31'd0, mem_req}, 32'd0);
    check("rsm_instret", instret, 32'd0);
    check("rsm_no_write", wr_addr_q.size(), 32'd0);
    hang = 1'b0;
    acc_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    @(negedge clk);
    rst = 1'b1;
    run_until_halt(100);
    if (acc_addr_q.size() >= 1) check("rsm_refetch", acc_addr_q[0], 32'h0);
    else check("rsm_refetch_cnt", acc_addr_q.size(), 32'd1);
    check("rsm_instret_end", instret, 32'd2);
    check("rsm_nwr", wr_addr_q.size(), 32'd1);

    check("bus_stable", unstable, 32'd0);
    check("bus_align", bad_align, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded at reset.
REQ-002 SHALL have parameter BUS_TIMEOUT, default 255, giving the maximum stall cycles per memory access; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port mem_req  output  1  memory access request, shared by instruction and data accesses.
REQ-006 SHALL have port mem_we  output  1  write strobe, valid while mem_req=1.
REQ-007 SHALL have port mem_addr  output  32  word address, always with bits [1:0] = 00.
REQ-008 SHALL have port mem_wdata  output  32  store data.
REQ-009 SHALL have port mem_rdata  input  32  read data, sampled in the cycle mem_ready=1.
REQ-010 SHALL have port mem_ready  input  1  access complete; ignored while mem_req=0.
REQ-011 SHALL have port halted  output  1  core stopped in HALT.
REQ-012 SHALL have port trap  output  1  halt caused by a fault: illegal instruction, misalignment or bus timeout.
REQ-013 SHALL have port retire  output  1  one-cycle pulse per completed instruction.
REQ-014 SHALL have port instret  output  32  count of retired instructions, wraps 32'hFFFF_FFFF -> 0.

Function
REQ-015 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT, with HALT terminal until reset.
REQ-016 SHALL execute add, sub, and, or, slt, addi, lui, lw, sw, beq, bne, jal and ebreak; any other opcode/funct combination SHALL be illegal.
REQ-017 SHALL in FETCH assert mem_req=1, mem_we=0, mem_addr=pc, holding these until mem_ready, then latch mem_rdata into IR and go to DECODE.
REQ-018 SHALL in DECODE latch rs1/rs2 register values and the sign-extended immediate (I/S/B/U/J formats).
REQ-019 SHALL in DECODE go to HALT with trap=1 on an illegal instruction, and go to HALT with trap=0 on ebreak.
REQ-020 SHALL in EXEC for beq/bne set pc to pc+imm if taken, else pc+4, pulse retire, and go to FETCH.
REQ-021 SHALL in EXEC for lw/sw compute rs1+imm, go to HALT with trap=1 if bits [1:0] != 0, otherwise go to MEM.
REQ-022 SHALL in EXEC for all other instructions go to WB.
REQ-023 SHALL in MEM assert mem_req=1, mem_addr=effective address, mem_we=1 for sw with mem_wdata=rs2 value; address, we and wdata SHALL stay stable until mem_ready.
REQ-024 SHALL on mem_ready in MEM go to WB for lw, and for sw set pc=pc+4, pulse retire and go to FETCH.
REQ-025 SHALL in WB write rd (ALU result, load data, lui immediate, or pc+4 for jal), with writes to x0 discarded and x0 always reading 0.
REQ-026 SHALL in WB set pc to pc+imm for jal, else pc+4, pulse retire and go to FETCH.
REQ-027 SHALL use a 32-bit register file; slt is signed; all arithmetic is modulo 2^32.
REQ-028 SHALL count wait cycles during each memory access; when the count reaches BUS_TIMEOUT without mem_ready it SHALL deassert mem_req and go to HALT with trap=1.
REQ-029 SHALL increment instret on every retire pulse.
REQ-030 SHALL have zero-wait-state latencies of: branch 3 cycles, ALU/lui/jal 4 cycles, sw 4 cycles, lw 5 cycles; each wait cycle adds 1.

Reset
REQ-031 SHALL, while rst=0, immediately (asynchronously) set pc=RESET_PC, state=FETCH, all registers=0, IR=0, instret=0, wait counter=0, and mem_req/mem_we/halted/trap/retire=0.
REQ-032 SHALL, on rst assertion mid-access, drop mem_req immediately; any pending write is abandoned and no register update occurs.
REQ-033 SHALL start the first fetch in the first rising edge after rst deasserts.

Verification
REQ-034 SHALL be checked with: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2 with zero wait -> x3=2, retire every 4 cycles, instret=3.
REQ-035 SHALL be checked with: sw x1,8(x0) then lw x4,8(x0), mem_ready delayed 3 cycles -> write at addr 8 data 5, x4=5, address/data stable throughout the stall.
REQ-036 SHALL be checked with: beq x0,x0,-8 at pc 0x10 -> next fetch at 0x08 after 3 cycles; bne x0,x0 -> next fetch at 0x14.
REQ-037 SHALL be checked with: opcode 7'b0000000 -> halted=1, trap=1, no further mem_req; ebreak -> halted=1, trap=0.
REQ-038 SHALL be checked with: lw at address 0x6 -> trap=1; mem_ready held low for BUS_TIMEOUT=4 -> HALT, trap=1, after 4 wait cycles.
REQ-039 SHALL be checked with: rst pulsed low during a MEM stall -> mem_req=0 immediately, pc=RESET_PC, instret=0, fetch resumes at RESET_PC.
